// File: rtl/mem_stage_pkg.sv
// Shared state encoding and default sizing for the memory stage and its store buffer.
package mem_stage_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_REG_AW   = 3;
    localparam int DEF_SB_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DUMP  = 2'd3
    } state_t;

endpackage

// File: rtl/memory_stage_sb_store_buf.sv
// FIFO of pending stores {addr, data} with a full-depth address match that
// returns the youngest matching entry for load forwarding.
module store_buf #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CW-1:0]     o_count,
    output logic              o_full
);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    // Pop is applied before push so a full-buffer push+pop on the same slot stays valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[r_rd_ptr + PW'(i)] && (r_addr[r_rd_ptr + PW'(i)] == i_lookup_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[r_rd_ptr + PW'(i)];
            end
        end
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = (r_count == CW'(DEPTH));

endmodule

// File: rtl/memory_stage_sb.sv
// Memory stage with a store buffer: stores retire into a FIFO that drains in the
// background; loads forward from the buffer or fetch from memory on a miss.
module memory_stage_sb
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AluRes,
    input  logic [DATA_W-1:0] RtIn,
    input  logic              RegWriteIn,
    input  logic              DMemWriteIn,
    input  logic              DMemEnIn,
    input  logic              MemToRegIn,
    input  logic              DMemDumpIn,
    input  logic [REG_AW-1:0] RdAddrIn,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWriteOut,
    output logic              DMemDumpOut,
    output logic [REG_AW-1:0] RdAddrOut,
    output logic              stall,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_dump,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_err
);

    localparam int CW = $clog2(SB_DEPTH + 1);

    state_t r_state;
    logic   r_dump_done;
    logic   r_err;

    logic              w_load, w_store, w_dump, w_load_miss;
    logic              w_hit, w_full, w_push, w_pop;
    logic              w_rd, w_wr;
    logic              w_ld_stall, w_st_stall, w_dp_stall, w_stall;
    logic [DATA_W-1:0] w_hit_data, w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [CW-1:0]     w_count;

    assign w_load      = DMemEnIn & ~DMemWriteIn;
    assign w_store     = DMemEnIn & DMemWriteIn;
    assign w_dump      = DMemDumpIn;
    assign w_load_miss = w_load & ~w_hit;

    // Commands are gated by reset so nothing reaches memory while rst is low.
    assign w_rd = rst & ((r_state == LOAD) | ((r_state == IDLE) & w_load_miss));
    assign w_wr = rst & (r_state == DRAIN);
    assign w_pop = (r_state == DRAIN) & mem_done;

    assign w_ld_stall = w_load_miss & ~(w_rd & mem_done);
    assign w_st_stall = w_store & w_full & ~w_pop;
    assign w_dp_stall = w_dump & ~r_dump_done;
    assign w_stall    = w_ld_stall | w_st_stall | w_dp_stall;
    assign w_push     = w_store & ~w_stall;

    store_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (SB_DEPTH)
    ) u_store_buf (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_push        (w_push),
        .i_push_addr   (AluRes),
        .i_push_data   (RtIn),
        .i_pop         (w_pop),
        .i_lookup_addr (AluRes),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_count       (w_count),
        .o_full        (w_full)
    );

    // A drain that has started always finishes; a load miss only preempts an idle slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_dump_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (mem_err & (w_rd | w_wr)) r_err <= 1'b1;
            if (r_state == DUMP)         r_dump_done <= 1'b1;
            else if (!w_stall)           r_dump_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load_miss) begin
                        if (!mem_done) r_state <= LOAD;
                    end else if (w_count != '0) begin
                        r_state <= DRAIN;
                    end else if (w_dump & ~r_dump_done) begin
                        r_state <= DUMP;
                    end
                end
                LOAD:    if (mem_done) r_state <= IDLE;
                DRAIN:   if (mem_done) r_state <= IDLE;
                DUMP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign RegWriteOut = RegWriteIn;
    assign DMemDumpOut = DMemDumpIn;
    assign RdAddrOut   = RdAddrIn;
    assign writeData   = MemToRegIn ? (w_hit ? w_hit_data : mem_rdata) : DATA_W'(AluRes);
    assign stall       = w_stall;
    assign err         = r_err;
    assign mem_addr    = (r_state == DRAIN) ? w_head_addr : AluRes;
    assign mem_wdata   = w_head_data;
    assign mem_rd      = w_rd;
    assign mem_wr      = w_wr;
    assign mem_dump    = rst & (r_state == DUMP);

endmodule

// File: tb/tb_memory_stage_sb.sv
// Bench for memory_stage_sb: vector table, directed multi-cycle sequences, and a
// randomized run checked against an architectural memory / pending-store model.
module tb_memory_stage_sb;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] AluRes;
    logic [DW-1:0] RtIn;
    logic          RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
    logic [RW-1:0] RdAddrIn;
    logic [DW-1:0] writeData;
    logic          RegWriteOut, DMemDumpOut;
    logic [RW-1:0] RdAddrOut;
    logic          stall, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr, mem_dump;
    logic [DW-1:0] mem_rdata;
    logic          mem_done, mem_err;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    memory_stage_sb #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .SB_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .AluRes(AluRes), .RtIn(RtIn),
        .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn), .DMemEnIn(DMemEnIn),
        .MemToRegIn(MemToRegIn), .DMemDumpIn(DMemDumpIn), .RdAddrIn(RdAddrIn),
        .writeData(writeData), .RegWriteOut(RegWriteOut), .DMemDumpOut(DMemDumpOut),
        .RdAddrOut(RdAddrOut), .stall(stall), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dump(mem_dump),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err)
    );

    typedef enum int {K_NOP, K_ST, K_LD, K_DUMP} kind_e;

    typedef struct {
        logic [AW-1:0] alu;
        logic          rw;
        logic [RW-1:0] rd;
        logic [DW-1:0] exp_wd;
        logic          exp_rw;
        logic [RW-1:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        AluRes      = a;
        RtIn        = d;
        DMemEnIn    = (k == K_ST) || (k == K_LD);
        DMemWriteIn = (k == K_ST);
        MemToRegIn  = (k == K_LD);
        RegWriteIn  = (k == K_LD);
        DMemDumpIn  = (k == K_DUMP);
    endtask

    task automatic flush();
        instr(K_NOP, '0, '0);
        mem_done = 1'b1;
        repeat (3 * D + 4) tick();
        mem_done = 1'b0;
    endtask

    // Reference model state: pending stores in program order, architectural view, backing memory.
    logic [AW-1:0] q_a[$];
    logic [DW-1:0] q_d[$];
    logic [DW-1:0] arch      [logic [AW-1:0]];
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] a);
        return arch.exists(a) ? arch[a] : (a ^ 16'h5A5A);
    endfunction

    initial begin
        vec_t          vecs[6];
        logic [AW-1:0] ga[$];
        logic [DW-1:0] gd[$];
        int            wrs, dumps, dcyc, rcyc;
        kind_e         k;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            held, busy, pop, s_stall, match;
        int            lat, hold, r;

        vecs[0] = '{16'h1234, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5};
        vecs[1] = '{16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0};
        vecs[2] = '{16'hFFFF, 1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7};
        vecs[3] = '{16'hA5A5, 1'b0, 3'd2, 16'hA5A5, 1'b0, 3'd2};
        vecs[4] = '{16'h8001, 1'b1, 3'd1, 16'h8001, 1'b1, 3'd1};
        vecs[5] = '{16'h0040, 1'b0, 3'd6, 16'h0040, 1'b0, 3'd6};

        instr(K_LD, 16'h0080, '0);
        RdAddrIn = '0; mem_done = 1'b1; mem_err = 1'b1; mem_rdata = '0;
        #2;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dump", mem_dump, 0);
        chk("rst_err", err, 0);
        tick(); tick();
        mem_done = 1'b0; mem_err = 1'b0;
        instr(K_NOP, '0, '0);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            instr(K_NOP, vecs[i].alu, '0);
            RegWriteIn = vecs[i].rw;
            RdAddrIn   = vecs[i].rd;
            #1;
            chk("vec_wd", writeData, vecs[i].exp_wd);
            chk("vec_rw", RegWriteOut, vecs[i].exp_rw);
            chk("vec_rd", RdAddrOut, vecs[i].exp_rd);
            chk("vec_stall", stall, 0);
            chk("vec_cmd", {mem_rd, mem_wr, mem_dump}, 0);
            tick();
        end
        RdAddrIn = '0;

        // Store then immediate load of the same address forwards from the buffer.
        instr(K_ST, 16'h0040, 16'hBEEF); #1;
        chk("fwd_st_stall", stall, 0);
        tick();
        instr(K_LD, 16'h0040, '0); #1;
        chk("fwd_wd", writeData, 16'hBEEF);
        chk("fwd_stall", stall, 0);
        chk("fwd_no_rd", mem_rd, 0);
        tick();
        instr(K_NOP, '0, '0); #1;
        chk("fwd_drain_wr", mem_wr, 1);
        chk("fwd_drain_addr", mem_addr, 16'h0040);
        chk("fwd_drain_data", mem_wdata, 16'hBEEF);
        chk("fwd_drain_no_rd", mem_rd, 0);
        flush();

        // Load miss with three busy cycles.
        instr(K_LD, 16'h0080, '0); mem_rdata = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("miss_rd", mem_rd, 1);
            chk("miss_addr", mem_addr, 16'h0080);
            chk("miss_stall", stall, 1);
            tick();
        end
        mem_done = 1'b1; #1;
        chk("miss_done_stall", stall, 0);
        chk("miss_wd", writeData, 16'h1234);
        tick();
        mem_done = 1'b0; instr(K_NOP, '0, '0); #1;
        chk("miss_idle_rd", mem_rd, 0);
        tick();

        // Two stores to one address; the load must see the younger one.
        instr(K_ST, 16'h0010, 16'h1111); tick();
        instr(K_ST, 16'h0010, 16'h2222); tick();
        instr(K_LD, 16'h0010, '0); #1;
        chk("young_wd", writeData, 16'h2222);
        chk("young_stall", stall, 0);
        chk("young_no_rd", mem_rd, 0);
        flush();

        // Five stores into a four-deep buffer with memory busy.
        for (int j = 0; j < 5; j++) begin
            instr(K_ST, 16'h0200 + 16'(j * 2), 16'hA000 + 16'(j)); #1;
            if (j < 4) begin
                chk("full_st_nostall", stall, 0);
                tick();
            end
        end
        for (int c = 0; c < 3; c++) begin
            chk("full_st5_stall", stall, 1);
            tick(); #1;
        end
        mem_done = 1'b1; #1;
        chk("full_release", stall, 0);
        chk("full_pop_wr", mem_wr, 1);
        chk("full_pop_addr", mem_addr, 16'h0200);
        chk("full_pop_data", mem_wdata, 16'hA000);
        tick();
        instr(K_NOP, '0, '0);
        for (int c = 0; c < 30; c++) begin
            #1;
            if (mem_wr && mem_done) begin ga.push_back(mem_addr); gd.push_back(mem_wdata); end
            tick();
        end
        mem_done = 1'b0;
        chk("full_drain_cnt", ga.size(), 4);
        for (int j = 0; j < ga.size() && j < 4; j++) begin
            chk("full_drain_addr", ga[j], 16'h0200 + 16'((j + 1) * 2));
            chk("full_drain_data", gd[j], 16'hA000 + 16'(j + 1));
        end

        // Dump with two buffered stores.
        instr(K_ST, 16'h0400, 16'h0A0A); tick();
        instr(K_ST, 16'h0402, 16'h0B0B); tick();
        instr(K_DUMP, '0, '0); mem_done = 1'b1;
        wrs = 0; dumps = 0; dcyc = -1; rcyc = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (mem_wr && mem_done) wrs++;
            if (mem_dump) begin
                dumps++; dcyc = c;
                chk("dump_after_wr", wrs, 2);
                chk("dump_no_rdwr", mem_rd | mem_wr, 0);
                chk("dump_pass", DMemDumpOut, 1);
            end
            if (!stall) begin rcyc = c; break; end
            tick();
        end
        chk("dump_pulses", dumps, 1);
        chk("dump_release", rcyc, dcyc + 1);
        tick();
        instr(K_NOP, '0, '0); mem_done = 1'b0; #1;
        chk("dump_gone", mem_dump, 0);
        tick();

        // Error during a drain, then reset in the middle of a load miss.
        instr(K_ST, 16'h0020, 16'h5555); tick();
        instr(K_NOP, '0, '0); tick();
        mem_err = 1'b1; #1;
        chk("err_drain_wr", mem_wr, 1);
        tick();
        mem_err = 1'b0; #1;
        chk("err_set", err, 1);
        mem_done = 1'b1; tick();
        mem_done = 1'b0; tick(); #1;
        chk("err_sticky", err, 1);
        tick();
        instr(K_ST, 16'h0300, 16'h7777); tick();
        instr(K_LD, 16'h0200, '0); #1;
        chk("rstld_rd", mem_rd, 1);
        tick(); #1;
        chk("rstld_rd_held", mem_rd, 1);
        rst = 1'b0; #1;
        chk("rstmid_rd", mem_rd, 0);
        chk("rstmid_wr", mem_wr, 0);
        chk("rstmid_err", err, 0);
        instr(K_NOP, '0, '0);
        tick(); tick();
        rst = 1'b1; #1;
        chk("post_rst_rd", mem_rd, 0);
        chk("post_rst_wr", mem_wr, 0);
        tick(); #1;
        chk("post_rst_no_drain", mem_wr, 0);
        chk("post_rst_err", err, 0);
        tick();
        instr(K_LD, 16'h0300, '0); #1;
        chk("post_rst_miss", mem_rd, 1);
        mem_done = 1'b1; mem_rdata = 16'hCAFE; #1;
        chk("post_rst_wd", writeData, 16'hCAFE);
        tick();
        mem_done = 1'b0;
        for (int j = 0; j < 5; j++) begin
            instr(K_ST, 16'h0500 + 16'(j * 2), 16'(j)); #1;
            chk("post_rst_cnt", stall, (j == 4));
            tick();
        end
        flush();

        // Randomized run against the reference model with a random-latency memory.
        k = K_NOP; a = '0; d = '0; held = 0; busy = 0; lat = 0; hold = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (!held) begin
                r = $urandom_range(0, 99);
                if (cyc >= 620)  k = K_NOP;
                else if (r < 40) k = K_ST;
                else if (r < 75) k = K_LD;
                else if (r < 95) k = K_NOP;
                else             k = K_DUMP;
                a = 16'h0100 + 16'($urandom_range(0, 5)) * 16'd2;
                d = 16'($urandom);
                RdAddrIn = 3'($urandom);
            end
            instr(k, a, d);
            #1;
            if ((mem_rd || mem_wr) && !busy) begin busy = 1; lat = $urandom_range(0, 3); end
            mem_done  = busy && (lat == 0);
            mem_rdata = mread(mem_addr);
            #1;
            pop = mem_wr && mem_done;
            chk("r_rdwr_excl", mem_rd & mem_wr, 0);
            chk("r_rdaddr", RdAddrOut, RdAddrIn);
            if (mem_rd) chk("r_rd_addr", mem_addr, a);
            if (pop) begin
                chk("r_wr_pending", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    chk("r_wr_addr", mem_addr, q_a[0]);
                    chk("r_wr_data", mem_wdata, q_d[0]);
                end
            end
            if (k == K_ST) chk("r_st_stall", stall, (q_a.size() == D) && !pop);
            if (k == K_LD) begin
                match = 0;
                foreach (q_a[i]) if (q_a[i] == a) match = 1;
                if (match) begin
                    chk("r_hit_no_rd", mem_rd, 0);
                    chk("r_hit_no_stall", stall, 0);
                end
                if (!stall) chk("r_ld_data", writeData, arch_rd(a));
            end
            if (mem_dump) chk("r_dump_empty", q_a.size(), 0);
            if (k == K_DUMP && !stall) chk("r_dump_rel_empty", q_a.size(), 0);
            if (held) chk("r_hold_bound", hold <= 60, 1);
            s_stall = stall;
            tick();
            if (busy) begin
                if (mem_done) busy = 0;
                else lat--;
            end
            if (pop && q_a.size() > 0) begin
                mem_model[q_a[0]] = q_d[0];
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end
            if (k == K_ST && !s_stall) begin
                q_a.push_back(a); q_d.push_back(d); arch[a] = d;
            end
            held = s_stall && (hold <= 60);
            hold = held ? hold + 1 : 0;
        end
        mem_done = 1'b0;
        chk("r_final_empty", q_a.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
